// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//   Parametrised register file with one write port and two combinational read
//   ports. It sits between decode and the ALU operand muxes. Features:
//     - two-address I/O window (no storage, raises io flags)
//     - optional hardwired zero register at address 0
//     - write-to-read bypass on both read ports
//     - per-register busy scoreboard for stalling consumers of pending loads
//
//   Ports
//     clk, rst            clock; synchronous active-high reset
//     wr_en/addr/data     write port (stores at the rising edge)
//     rd_addr1/2          read port addresses
//     rsv_en/rsv_addr     reserve: mark an address busy (pending load)
//     rd_data1/2          read data (combinational)
//     rd_io1/2, wr_io     {IO_ADDR1, IO_ADDR0} hit flags; wr_io gated by wr_en
//     rd_busy1/2          operand not yet valid
//
//   There is no valid/ready handshake on this block: wr_en and rsv_en are
//   single-cycle strobes that are acted on at the edge where they are high,
//   and every output is a pure function of current state and current inputs.
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int IO_ADDR0 = 6,
  parameter int IO_ADDR1 = 7,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [1:0]        rd_io1,
  output logic [1:0]        rd_io2,
  output logic [1:0]        wr_io,
  output logic              rd_busy1,
  output logic              rd_busy2
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Window addresses are compared at 32 bits so a window placed beyond DEPTH
  // simply never matches instead of aliasing onto a truncated address.
  localparam logic [31:0] IO0_W = 32'(IO_ADDR0);
  localparam logic [31:0] IO1_W = 32'(IO_ADDR1);

  function automatic logic hit_io0(input logic [ADDR_W-1:0] a);
    return 32'(a) == IO0_W;
  endfunction

  function automatic logic hit_io1(input logic [ADDR_W-1:0] a);
    return 32'(a) == IO1_W;
  endfunction

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // An address with real storage and a real busy bit.
  function automatic logic storable(input logic [ADDR_W-1:0] a);
    return !hit_io0(a) && !hit_io1(a) && !is_zero(a);
  endfunction

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              wr_ok;
  logic              rsv_ok;

  assign wr_ok  = wr_en  && storable(wr_addr);
  assign rsv_ok = rsv_en && storable(rsv_addr);

  // Next state: a write clears busy, a same-cycle reserve then sets it again,
  // so the reservation wins while the data is still stored.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    if (rsv_ok) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read ports, handled as a two-entry array so both follow identical rules.
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];
  logic [1:0]        rd_io   [2];
  logic              rd_busy [2];

  assign rd_addr[0] = rd_addr1;
  assign rd_addr[1] = rd_addr2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_io[p]   = {hit_io1(rd_addr[p]), hit_io0(rd_addr[p])};
      rd_data[p] = '0;
      rd_busy[p] = 1'b0;
      // I/O and zero addresses leave data and busy at 0.
      if (storable(rd_addr[p])) begin
        if (wr_en && (wr_addr == rd_addr[p])) begin
          // Bypass: the value being written is the value the consumer wants,
          // so it is valid now regardless of the scoreboard.
          rd_data[p] = wr_data;
        end else begin
          rd_data[p] = regs_q[rd_addr[p]];
          rd_busy[p] = busy_q[rd_addr[p]];
        end
      end
    end
  end

  assign rd_data1 = rd_data[0];
  assign rd_data2 = rd_data[1];
  assign rd_io1   = rd_io[0];
  assign rd_io2   = rd_io[1];
  assign rd_busy1 = rd_busy[0];
  assign rd_busy2 = rd_busy[1];
  assign wr_io    = wr_en ? {hit_io1(wr_addr), hit_io0(wr_addr)} : 2'b00;

endmodule
